ms_mul_job_ctrl: RTL
====================

# ms_mul_job_ctrl

Job sequencer for the serial-by-2 stochastic multiplier datapath. It accepts one operand set per job over a valid/ready handshake and holds the operands stable for the multiplier. It clears the multiplier, enables it, and waits for its done flag, with a timeout guard. It then captures the binary count result with a run-length stamp and presents it downstream over a second valid/ready handshake, so the multiplier can be driven from a stream rather than a testbench.

## Interface
- DATA_WIDTH, 5, bits per operand
- NUM_INPUTS, 2, number of operands per job (2..5)
- DRAIN_CYCLES, 1, cycles waited after done before sampling the accumulator (1..3)
- TIMEOUT, 2**((DATA_WIDTH-1)*NUM_INPUTS)+16, max RUN cycles before abort
- Derived: RES_W = DATA_WIDTH*NUM_INPUTS; CNT_W = RES_W+1
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  operand set valid
- in_ready  out  1  controller can accept a job
- in_data  in  RES_W  packed operands; operand i = in_data[i*DATA_WIDTH +: DATA_WIDTH]
- mul_clr  out  1  active-high clear pulse to multiplier (drives its rst)
- mul_en  out  1  multiplier enable
- mul_data  out  RES_W  latched operands, same packing as in_data
- mul_done  in  1  multiplier done flag
- mul_result  in  RES_W  multiplier accumulator count
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_data  out  RES_W  captured result
- out_cycles  out  CNT_W  RUN cycles consumed by the job
- out_err  out  1  job aborted by timeout

## Operation
- FSM states: IDLE, CLEAR, RUN, DRAIN, HOLD.
- IDLE: in_ready=1. On in_valid&in_ready, latch in_data into mul_data and go to CLEAR.
- CLEAR: mul_clr=1 for exactly one cycle. Clear run_cnt and drain_cnt. Go to RUN.
- RUN: mul_en=1 and run_cnt increments every cycle.
  - If mul_done=1, go to DRAIN; run_cnt includes that cycle.
  - Else if run_cnt+1 == TIMEOUT, set err and go to DRAIN.
  - If both conditions hold in the same cycle, done wins and err=0.
- DRAIN: mul_en=0. drain_cnt counts to DRAIN_CYCLES. On the last DRAIN cycle, register out_data<=mul_result, out_cycles<=run_cnt, out_err<=err, then go to HOLD.
- HOLD: out_valid=1. On out_ready, go to IDLE. out_data, out_cycles and out_err stay stable while out_valid=1 and out_ready=0.
- mul_data holds its value from acceptance until the next acceptance; it is never changed mid-job.
- mul_done is ignored outside RUN, including any stale high during CLEAR.
- run_cnt saturates at 2**CNT_W-1. It cannot wrap because TIMEOUT < 2**CNT_W.
- Reset (any state, including mid-RUN) takes effect immediately and returns to IDLE. Reset values: in_ready=1 (after release), mul_clr=0, mul_en=0, mul_data=0, out_valid=0, out_data=0, out_cycles=0, out_err=0.

## Timing
- All outputs are registered or decoded from the state register only; there is no combinational in->out path.
- Job accepted at edge T: CLEAR during T+1, RUN from T+2.
- mul_done sampled high at edge D: DRAIN cycles D+1..D+DRAIN_CYCLES, out_valid high from D+DRAIN_CYCLES+1.
- HOLD->IDLE on the out_ready edge. The next job can be accepted at the following edge: one bubble cycle, with no overlap between jobs.
- Ideal job latency (acceptance to out_valid) = 2 + N_run + DRAIN_CYCLES, where N_run = 2**((DATA_WIDTH-1)*NUM_INPUTS) for the stride-2 generators.

## Structure
- Shared package: FSM state enum (3-bit encoding), RES_W/CNT_W derivation functions, and the default TIMEOUT expression.
- One sub-module is natural: ms_job_run_counter (saturating run counter plus timeout compare, CNT_W wide), reused by future adder and scaler sequencers.
- The multiplier is not instantiated here; the integration top wires mul_* ports.

## Test plan
- Behavioural multiplier model (done after 256 enabled cycles, result = a*b), W=5, N=2. Send a=3, b=5 -> out_data=15, out_cycles=256, out_err=0, out_valid at acceptance+259.
- Model never asserts done, TIMEOUT=300 -> out_err=1, out_cycles=300, mul_en drops after cycle 300, single out_valid.
- Hold out_ready=0 for 10 cycles in HOLD -> out_data, out_cycles and out_err are stable; in_ready=0; second in_valid is not accepted until 1 cycle after out_ready.
- Assert rst mid-RUN (cycle 100) -> mul_en=0 and out_valid=0 immediately. After release, in_ready=1, and a new job a=31, b=31 yields 961.
- Done and timeout in the same cycle (model done at 300, TIMEOUT=300) -> out_err=0, out_cycles=300.
- Three back-to-back jobs with out_ready=1 -> results in order, exactly one bubble between each handshake, one mul_clr pulse per job.

Source files
------------

// File: rtl/ms_mul_job_ctrl_pkg.sv
// Shared definitions for the stochastic-multiplier job sequencer:
// FSM state encoding, width derivations and the default timeout.
package ms_mul_job_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_HOLD  = 3'd4
    } state_e;

    localparam int DEF_DATA_WIDTH   = 5;
    localparam int DEF_NUM_INPUTS   = 2;
    localparam int DEF_DRAIN_CYCLES = 1;

    // Width of the packed operand bus and of the result count.
    function automatic int res_w(input int dw, input int n);
        return dw * n;
    endfunction

    // Run counter width: one bit wider than the result so the timeout fits.
    function automatic int cnt_w(input int dw, input int n);
        return dw * n + 1;
    endfunction

    // Ideal run length of the stride-2 generators plus a small margin.
    function automatic int default_timeout(input int dw, input int n);
        return (1 << ((dw - 1) * n)) + 16;
    endfunction

    localparam int DEF_TIMEOUT = default_timeout(DEF_DATA_WIDTH, DEF_NUM_INPUTS);

endpackage

// File: rtl/ms_mul_job_ctrl_if.sv
// Bundle of the job input stream, multiplier control and result stream.
// master = the sequencer, slave = its environment (source, multiplier, sink).
interface ms_mul_job_ctrl_if
    import ms_mul_job_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_INPUTS = DEF_NUM_INPUTS
);
    localparam int RES_W = res_w(DATA_WIDTH, NUM_INPUTS);
    localparam int CNT_W = cnt_w(DATA_WIDTH, NUM_INPUTS);

    logic             in_valid;
    logic             in_ready;
    logic [RES_W-1:0] in_data;
    logic             mul_clr;
    logic             mul_en;
    logic [RES_W-1:0] mul_data;
    logic             mul_done;
    logic [RES_W-1:0] mul_result;
    logic             out_valid;
    logic             out_ready;
    logic [RES_W-1:0] out_data;
    logic [CNT_W-1:0] out_cycles;
    logic             out_err;

    modport master (
        input  in_valid, in_data, mul_done, mul_result, out_ready,
        output in_ready, mul_clr, mul_en, mul_data,
        output out_valid, out_data, out_cycles, out_err
    );

    modport slave (
        output in_valid, in_data, mul_done, mul_result, out_ready,
        input  in_ready, mul_clr, mul_en, mul_data,
        input  out_valid, out_data, out_cycles, out_err
    );

endinterface

// File: rtl/ms_job_run_counter.sv
// Saturating run-length counter with a timeout compare, shared by the
// stochastic arithmetic job sequencers.
module ms_job_run_counter
    import ms_mul_job_ctrl_pkg::*;
#(
    parameter int CNT_W   = cnt_w(DEF_DATA_WIDTH, DEF_NUM_INPUTS),
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             timeout_hit
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] SAT  = '1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear wins, otherwise count enabled cycles up to all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != SAT)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Count register, cleared asynchronously by the active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt         = cnt_q;
    assign timeout_hit = (cnt_q == LAST);

endmodule

// File: rtl/ms_mul_job_ctrl.sv
// Job sequencer for the serial-by-2 stochastic multiplier: accepts an
// operand set, clears and runs the multiplier until done or timeout, then
// offers the count, run length and abort flag on the result stream.
module ms_mul_job_ctrl
    import ms_mul_job_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int NUM_INPUTS   = DEF_NUM_INPUTS,
    parameter int DRAIN_CYCLES = DEF_DRAIN_CYCLES,
    parameter int TIMEOUT      = default_timeout(DATA_WIDTH, NUM_INPUTS)
) (
    input  logic              clk,
    input  logic              rst,
    ms_mul_job_ctrl_if.master bus
);
    localparam int RES_W = res_w(DATA_WIDTH, NUM_INPUTS);
    localparam int CNT_W = cnt_w(DATA_WIDTH, NUM_INPUTS);
    localparam logic [1:0] DRAIN_LAST = 2'(DRAIN_CYCLES - 1);

    state_e           state_q,      state_d;
    logic [RES_W-1:0] mul_data_q,   mul_data_d;
    logic [RES_W-1:0] out_data_q,   out_data_d;
    logic [CNT_W-1:0] out_cycles_q, out_cycles_d;
    logic             out_err_q,    out_err_d;
    logic             err_q,        err_d;
    logic [1:0]       drain_cnt_q,  drain_cnt_d;

    logic             run_clr;
    logic             run_en;
    logic             timeout_hit;
    logic [CNT_W-1:0] run_cnt;

    assign run_clr = (state_q == ST_CLEAR);
    assign run_en  = (state_q == ST_RUN);

    ms_job_run_counter #(
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
    ) u_run_counter (
        .clk         (clk),
        .rst         (rst),
        .clr         (run_clr),
        .en          (run_en),
        .cnt         (run_cnt),
        .timeout_hit (timeout_hit)
    );

    // Next-state and datapath updates; mul_done is only looked at in RUN.
    always_comb begin
        state_d      = state_q;
        mul_data_d   = mul_data_q;
        out_data_d   = out_data_q;
        out_cycles_d = out_cycles_q;
        out_err_d    = out_err_q;
        err_d        = err_q;
        drain_cnt_d  = drain_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    mul_data_d = bus.in_data;
                    state_d    = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                err_d       = 1'b0;
                drain_cnt_d = '0;
                state_d     = ST_RUN;
            end
            ST_RUN: begin
                if (bus.mul_done) begin
                    err_d   = 1'b0;
                    state_d = ST_DRAIN;
                end else if (timeout_hit) begin
                    err_d   = 1'b1;
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (drain_cnt_q == DRAIN_LAST) begin
                    out_data_d   = bus.mul_result;
                    out_cycles_d = run_cnt;
                    out_err_d    = err_q;
                    state_d      = ST_HOLD;
                end else begin
                    drain_cnt_d = drain_cnt_q + 2'd1;
                end
            end
            ST_HOLD: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and captured-value registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            mul_data_q   <= '0;
            out_data_q   <= '0;
            out_cycles_q <= '0;
            out_err_q    <= 1'b0;
            err_q        <= 1'b0;
            drain_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            mul_data_q   <= mul_data_d;
            out_data_q   <= out_data_d;
            out_cycles_q <= out_cycles_d;
            out_err_q    <= out_err_d;
            err_q        <= err_d;
            drain_cnt_q  <= drain_cnt_d;
        end
    end

    assign bus.in_ready   = (state_q == ST_IDLE);
    assign bus.mul_clr    = (state_q == ST_CLEAR);
    assign bus.mul_en     = (state_q == ST_RUN);
    assign bus.out_valid  = (state_q == ST_HOLD);
    assign bus.mul_data   = mul_data_q;
    assign bus.out_data   = out_data_q;
    assign bus.out_cycles = out_cycles_q;
    assign bus.out_err    = out_err_q;

endmodule
